adc_frame_tx: RTL and testbench
===============================

Name: adc_frame_tx

Overview:
- Downstream stage after the AD7864 readout path: collects one 12-bit sample per channel (4 channels) per conversion.
- Packs them into a 64-bit frame and shifts it to the DSP McBSP receive port.
- Generates its own bit clock (bclk), frame sync (fsx) and serial data (dx).
- Double-buffered: the next frame's samples are captured while the current frame is shifting.

Parameters:
- NCH, 4, channels per frame (ch index width fixed at 2 bits)
- DATA_W, 12, ADC sample width
- WORD_W, 16, serial word width per channel
- CLK_DIV, 2, bclk half-period in clkin cycles (>=1)

Ports:
- clkin  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- smp_valid  in  1  one-cycle strobe: smp_ch/smp_data valid
- smp_ch  in  2  channel index of sample
- smp_data  in  12  sample value
- ovr_clr  in  1  clears sticky overrun flag
- bclk  out  1  serial bit clock to DSP (CLKR)
- fsx  out  1  frame sync to DSP (FSR)
- dx  out  1  serial data to DSP (DR), MSB first
- busy  out  1  frame shifting in progress
- overrun  out  1  sticky: frame dropped because transmitter was busy

Behaviour:
- Reset (async): bclk=0, fsx=0, dx=0, busy=0, overrun=0; capture buffer, written-mask and shadow register cleared; FSM to IDLE. Mid-frame reset aborts the frame immediately.
- Capture:
  - On smp_valid, buf[smp_ch] <= smp_data and mask[smp_ch] <= 1.
  - Capture is independent of the FSM and runs during SHIFT.
- Frame completion event: smp_valid with smp_ch==NCH-1, sampled in cycle N.
  - If FSM==IDLE in cycle N: shadow loaded at N+1. Word k = {k[1:0], 1'b0, stale_k, data_k}.
    - stale_k = ~mask[k]; data_k = 0 when stale.
    - Channel 3 uses the smp_data of cycle N (bypass).
    - Shadow = {word0, word1, word2, word3}, word0 in bits 63:48.
  - If FSM!=IDLE in cycle N (including the last cycle of SHIFT): frame dropped and overrun <= 1.
  - In both cases, mask <= 0 at N+1.
- ovr_clr clears overrun. Simultaneous set and clear: set wins.
- FSM states:
  - IDLE: busy=0, bclk=0.
  - LOAD: 1 cycle (N+1). dx=bit63, fsx=1, busy=1, bclk=0.
  - SHIFT: bclk toggles every CLK_DIV cycles, starting low.
    - dx/fsx change only on bclk high->low transitions; DSP samples on the rising edge.
    - Each bit is held 2*CLK_DIV cycles.
    - fsx=1 for exactly the first bit period only.
  - Transition: SHIFT->IDLE on the falling edge that ends bit 0. dx=0 and busy=0 on that same cycle.
- Latency: first bclk rising edge at N+1+CLK_DIV. busy high for 64*2*CLK_DIV cycles (256 at default).
- Bit counter: 6-bit, counts 63->0, no wrap. A new frame is accepted from the first IDLE cycle onward.
- Duplicate channel write within a frame: last write wins. smp_ch==3 always completes the frame, even if channels 0-2 are absent (they are sent marked stale).

Decomposition:
- Package adc_frame_pkg: NCH, DATA_W, WORD_W, FRAME_W (=NCH*WORD_W), FSM state enum (IDLE, LOAD, SHIFT), word-format field offsets.
- Sub-module adc_bclk_gen: CLK_DIV half-period counter. Outputs bclk, rise_stb and fall_stb; enabled by FSM, forced low when disabled.

Test Plan:
- Nominal frame: valid ch0..3 with data 0x123, 0x456, 0x789, 0xABC on consecutive cycles -> fsx high for the first 4 cycles. On bclk rising edges the DSP-side capture reads 0x0123, 0x4456, 0x8789, 0xCABC. busy=256 cycles, overrun=0.
- Stale channel: only ch0=0x0FF and ch3=0x001 -> words 0x00FF, 0x5000, 0x9000, 0xC001.
- Overrun: complete frame A, then complete frame B 100 cycles later (busy) -> B dropped, overrun=1, frame A bits unchanged. Pulse ovr_clr -> overrun=0. Frame C completed after busy falls transmits normally.
- Boundary: ch3 strobe on the final SHIFT cycle -> dropped, overrun=1. ch3 strobe one cycle later (IDLE) -> LOAD on the next cycle.
- Overlap capture: write ch0..2 of frame B during frame A shift, then ch3 after busy falls -> frame B carries those values and none are stale.
- Reset mid-frame: assert rst at bit 30 -> bclk, fsx, dx, busy, overrun=0 asynchronously. After release, a new frame shifts correctly. Repeat the nominal test with CLK_DIV=1 and CLK_DIV=3.

Source files
------------

// File: rtl/adc_frame_pkg.sv
// Shared constants, FSM encoding and serial word layout for the ADC frame transmitter.
// Each 16-bit word is laid out as {channel[1:0], 1'b0, stale, data[11:0]}.
package adc_frame_pkg;

    localparam int NCH       = 4;
    localparam int DATA_W    = 12;
    localparam int WORD_W    = 16;
    localparam int CH_W      = 2;
    localparam int FRAME_W   = NCH * WORD_W;
    localparam int BIT_CNT_W = $clog2(FRAME_W);

    localparam int WORD_CH_LSB    = 14;
    localparam int WORD_STALE_BIT = 12;
    localparam int WORD_DATA_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // A stale word always carries zero data so the DSP never sees leftovers.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [CH_W-1:0]   ch,
        input logic              stale,
        input logic [DATA_W-1:0] data
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[WORD_CH_LSB +: CH_W]     = ch;
        w[WORD_STALE_BIT]          = stale;
        w[WORD_DATA_LSB +: DATA_W] = stale ? '0 : data;
        return w;
    endfunction

endpackage

// File: rtl/adc_frame_tx_if.sv
// Sample-capture bus plus the McBSP-side serial outputs of the frame transmitter.
interface adc_frame_tx_if;
    import adc_frame_pkg::*;

    logic              smp_valid;
    logic [CH_W-1:0]   smp_ch;
    logic [DATA_W-1:0] smp_data;
    logic              ovr_clr;
    logic              bclk;
    logic              fsx;
    logic              dx;
    logic              busy;
    logic              overrun;

    modport master (
        output smp_valid, smp_ch, smp_data, ovr_clr,
        input  bclk, fsx, dx, busy, overrun
    );

    modport slave (
        input  smp_valid, smp_ch, smp_data, ovr_clr,
        output bclk, fsx, dx, busy, overrun
    );

endinterface

// File: rtl/adc_bclk_gen.sv
// Bit-clock generator: bclk toggles every CLK_DIV enabled cycles, starting low.
// The strobes flag the cycle whose closing edge produces the next bclk transition.
module adc_bclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clkin,
    input  logic rst,
    input  logic en,
    output logic bclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             bclk_reg;
    logic             term;

    assign term     = en && (cnt_reg == TERM);
    assign rise_stb = term && !bclk_reg;
    assign fall_stb = term && bclk_reg;
    assign bclk     = bclk_reg;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            cnt_reg  <= '0;
            bclk_reg <= 1'b0;
        end else if (!en) begin
            cnt_reg  <= '0;
            bclk_reg <= 1'b0;
        end else if (term) begin
            cnt_reg  <= '0;
            bclk_reg <= ~bclk_reg;
        end else begin
            cnt_reg  <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/adc_frame_tx.sv
// Collects one sample per channel, packs a 64-bit frame and shifts it MSB first
// to a McBSP receiver with self-generated bclk/fsx. Capture runs while shifting.
module adc_frame_tx
    import adc_frame_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic           clkin,
    input  logic           rst,
    adc_frame_tx_if.slave  bus
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

    state_t                 state_reg, state_next;
    logic [BIT_CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [FRAME_W-1:0]     shadow_reg, shadow_next;
    logic                   fsx_reg, fsx_next;
    logic                   overrun_reg, overrun_next;

    // The last channel is taken straight from the bus, so only NCH-1 are stored.
    logic [DATA_W-1:0]      cap_reg [NCH-1];
    logic [NCH-2:0]         mask_reg;
    logic [FRAME_W-1:0]     frame_word;
    logic                   frame_done;
    logic                   gen_en;
    logic                   fall_stb;
    logic                   unused_rise_stb;

    assign frame_done = bus.smp_valid && (bus.smp_ch == LAST_CH);
    assign gen_en     = (state_reg != IDLE);

    adc_bclk_gen #(
        .CLK_DIV  (CLK_DIV)
    ) u_bclk_gen (
        .clkin    (clkin),
        .rst      (rst),
        .en       (gen_en),
        .bclk     (bus.bclk),
        .rise_stb (unused_rise_stb),
        .fall_stb (fall_stb)
    );

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH - 1; i++) cap_reg[i] <= '0;
            mask_reg <= '0;
        end else begin
            for (int i = 0; i < NCH - 1; i++) begin
                if (bus.smp_valid && (bus.smp_ch == CH_W'(i))) begin
                    cap_reg[i]  <= bus.smp_data;
                    mask_reg[i] <= 1'b1;
                end
            end
            if (frame_done) mask_reg <= '0;
        end
    end

    // Word 0 occupies the top of the frame so it leaves first.
    genvar gi;
    generate
        for (gi = 0; gi < NCH - 1; gi++) begin : g_word
            assign frame_word[FRAME_W-1-gi*WORD_W -: WORD_W] =
                pack_word(CH_W'(gi), ~mask_reg[gi], cap_reg[gi]);
        end
    endgenerate
    assign frame_word[WORD_W-1:0] = pack_word(LAST_CH, 1'b0, bus.smp_data);

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shadow_reg  <= '0;
            fsx_reg     <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shadow_reg  <= shadow_next;
            fsx_reg     <= fsx_next;
            overrun_reg <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shadow_next  = shadow_reg;
        fsx_next     = fsx_reg;
        overrun_next = overrun_reg;

        if (bus.ovr_clr) overrun_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (frame_done) begin
                    state_next   = LOAD;
                    shadow_next  = frame_word;
                    fsx_next     = 1'b1;
                    bit_cnt_next = '1;
                end
            end
            LOAD: state_next = SHIFT;
            SHIFT: begin
                // Zero fill leaves dx low once all 64 bits have gone out.
                if (fall_stb) begin
                    shadow_next = {shadow_reg[FRAME_W-2:0], 1'b0};
                    fsx_next    = 1'b0;
                    if (bit_cnt_reg == '0) state_next = IDLE;
                    else                   bit_cnt_next = bit_cnt_reg - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (frame_done && (state_reg != IDLE)) overrun_next = 1'b1;
    end

    assign bus.dx      = shadow_reg[FRAME_W-1];
    assign bus.fsx     = fsx_reg;
    assign bus.busy    = (state_reg != IDLE);
    assign bus.overrun = overrun_reg;

endmodule

// File: tb/tb_adc_frame_tx.sv
// Directed bench: three transmitters (CLK_DIV 1/2/3) with DSP-side receivers
// that shift dx in on every bclk rising edge.
module tb_adc_frame_tx;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    adc_frame_tx_if if1();
    adc_frame_tx_if if2();
    adc_frame_tx_if if3();

    adc_frame_tx #(.CLK_DIV(1)) dut1 (.clkin(clk), .rst(rst), .bus(if1));
    adc_frame_tx #(.CLK_DIV(2)) dut2 (.clkin(clk), .rst(rst), .bus(if2));
    adc_frame_tx #(.CLK_DIV(3)) dut3 (.clkin(clk), .rst(rst), .bus(if3));

    always #5 clk = ~clk;

    logic [63:0] rx1 = '0, rx2 = '0, rx3 = '0;
    int busy_cnt1 = 0, busy_cnt2 = 0, busy_cnt3 = 0;
    int fsx_cnt1 = 0, fsx_cnt2 = 0, fsx_cnt3 = 0;

    always @(posedge if1.bclk) rx1 <= {rx1[62:0], if1.dx};
    always @(posedge if2.bclk) rx2 <= {rx2[62:0], if2.dx};
    always @(posedge if3.bclk) rx3 <= {rx3[62:0], if3.dx};

    always @(posedge clk) begin
        if (if1.busy) busy_cnt1 <= busy_cnt1 + 1;
        if (if1.fsx)  fsx_cnt1  <= fsx_cnt1 + 1;
    end
    always @(posedge clk) begin
        if (if2.busy) busy_cnt2 <= busy_cnt2 + 1;
        if (if2.fsx)  fsx_cnt2  <= fsx_cnt2 + 1;
    end
    always @(posedge clk) begin
        if (if3.busy) busy_cnt3 <= busy_cnt3 + 1;
        if (if3.fsx)  fsx_cnt3  <= fsx_cnt3 + 1;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ch, input logic [11:0] d, input bit all);
        if2.smp_valid = 1'b1; if2.smp_ch = ch; if2.smp_data = d;
        if (all) begin
            if1.smp_valid = 1'b1; if1.smp_ch = ch; if1.smp_data = d;
            if3.smp_valid = 1'b1; if3.smp_ch = ch; if3.smp_data = d;
        end
        @(negedge clk);
        if1.smp_valid = 1'b0;
        if2.smp_valid = 1'b0;
        if3.smp_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [11:0] d0, input logic [11:0] d1,
                              input logic [11:0] d2, input logic [11:0] d3, input bit all);
        drive(2'd0, d0, all);
        drive(2'd1, d1, all);
        drive(2'd2, d2, all);
        drive(2'd3, d3, all);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((if1.busy || if2.busy || if3.busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk1({tag, "_idle_timeout"}, if1.busy | if2.busy | if3.busy, 1'b0);
    endtask

    task automatic pulse_ovr_clr();
        if2.ovr_clr = 1'b1;
        @(negedge clk);
        if2.ovr_clr = 1'b0;
    endtask

    int sb1, sb2, sb3, sf1, sf2, sf3;

    initial begin
        rst = 1'b1;
        if1.smp_valid = 1'b0; if1.smp_ch = '0; if1.smp_data = '0; if1.ovr_clr = 1'b0;
        if2.smp_valid = 1'b0; if2.smp_ch = '0; if2.smp_data = '0; if2.ovr_clr = 1'b0;
        if3.smp_valid = 1'b0; if3.smp_ch = '0; if3.smp_data = '0; if3.ovr_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_bclk", if2.bclk, 1'b0);
        chk1("rst_fsx", if2.fsx, 1'b0);
        chk1("rst_dx", if2.dx, 1'b0);
        chk1("rst_busy", if2.busy, 1'b0);
        chk1("rst_overrun", if2.overrun, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal frame on all three dividers
        sb1 = busy_cnt1; sb2 = busy_cnt2; sb3 = busy_cnt3;
        sf1 = fsx_cnt1;  sf2 = fsx_cnt2;  sf3 = fsx_cnt3;
        send_frame(12'h123, 12'h456, 12'h789, 12'hABC, 1'b1);
        chk1("nom_load_busy", if2.busy, 1'b1);
        chk1("nom_load_fsx", if2.fsx, 1'b1);
        chk1("nom_load_bclk", if2.bclk, 1'b0);
        wait_idle("nom");
        chk64("nom_rx_div2", rx2, 64'h0123_4456_8789_CABC);
        chk_int("nom_busy_div2", busy_cnt2 - sb2, 256);
        chk_int("nom_fsx_div2", fsx_cnt2 - sf2, 4);
        chk1("nom_overrun", if2.overrun, 1'b0);
        chk1("nom_idle_dx", if2.dx, 1'b0);
        chk64("nom_rx_div1", rx1, 64'h0123_4456_8789_CABC);
        chk_int("nom_busy_div1", busy_cnt1 - sb1, 128);
        chk_int("nom_fsx_div1", fsx_cnt1 - sf1, 2);
        chk64("nom_rx_div3", rx3, 64'h0123_4456_8789_CABC);
        chk_int("nom_busy_div3", busy_cnt3 - sb3, 384);
        chk_int("nom_fsx_div3", fsx_cnt3 - sf3, 6);

        // Stale channels 1 and 2
        drive(2'd0, 12'h0FF, 1'b0);
        drive(2'd3, 12'h001, 1'b0);
        wait_idle("stale");
        chk64("stale_rx", rx2, 64'h00FF_5000_9000_C001);

        // Overrun: frame B completes while A is still shifting
        send_frame(12'h111, 12'h222, 12'h333, 12'h444, 1'b0);
        repeat (100) @(negedge clk);
        chk1("ovr_before", if2.overrun, 1'b0);
        send_frame(12'hEEE, 12'hDDD, 12'hCCC, 12'hBBB, 1'b0);
        chk1("ovr_set", if2.overrun, 1'b1);
        chk1("ovr_still_busy", if2.busy, 1'b1);
        wait_idle("ovr_a");
        chk64("ovr_rx_a", rx2, 64'h0111_4222_8333_C444);
        chk1("ovr_sticky", if2.overrun, 1'b1);
        pulse_ovr_clr();
        chk1("ovr_cleared", if2.overrun, 1'b0);
        send_frame(12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD, 1'b0);
        wait_idle("ovr_c");
        chk64("ovr_rx_c", rx2, 64'h0AAA_4BBB_8CCC_CDDD);

        // Boundary: latency, fsx width, completion on final SHIFT cycle
        drive(2'd3, 12'h5A5, 1'b0);
        chk1("bnd_load_busy", if2.busy, 1'b1);
        chk1("bnd_load_bclk", if2.bclk, 1'b0);
        @(negedge clk);
        chk1("bnd_pre_rise_bclk", if2.bclk, 1'b0);
        @(negedge clk);
        chk1("bnd_first_rise_bclk", if2.bclk, 1'b1);
        chk1("bnd_first_rise_fsx", if2.fsx, 1'b1);
        repeat (2) @(negedge clk);
        chk1("bnd_bit62_bclk", if2.bclk, 1'b0);
        chk1("bnd_bit62_fsx", if2.fsx, 1'b0);
        repeat (251) @(negedge clk);
        chk1("bnd_last_shift_busy", if2.busy, 1'b1);
        if2.smp_valid = 1'b1; if2.smp_ch = 2'd3; if2.smp_data = 12'h777; if2.ovr_clr = 1'b1;
        @(negedge clk);
        if2.smp_valid = 1'b0; if2.ovr_clr = 1'b0;
        chk1("bnd_first_idle_busy", if2.busy, 1'b0);
        chk1("bnd_set_wins", if2.overrun, 1'b1);
        chk1("bnd_first_idle_dx", if2.dx, 1'b0);
        drive(2'd3, 12'h123, 1'b0);
        chk1("bnd_accept_busy", if2.busy, 1'b1);
        chk1("bnd_accept_fsx", if2.fsx, 1'b1);
        wait_idle("bnd");
        chk64("bnd_rx", rx2, 64'h1000_5000_9000_C123);
        pulse_ovr_clr();

        // Overlap capture: next frame's channels written during shift
        send_frame(12'h123, 12'h456, 12'h789, 12'hABC, 1'b0);
        repeat (50) @(negedge clk);
        drive(2'd0, 12'h321, 1'b0);
        drive(2'd1, 12'h654, 1'b0);
        drive(2'd2, 12'h987, 1'b0);
        wait_idle("olap_a");
        chk64("olap_rx_a", rx2, 64'h0123_4456_8789_CABC);
        drive(2'd3, 12'hFED, 1'b0);
        wait_idle("olap_b");
        chk64("olap_rx_b", rx2, 64'h0321_4654_8987_CFED);
        chk1("olap_overrun", if2.overrun, 1'b0);

        // Reset in the middle of bit 30
        send_frame(12'h123, 12'h456, 12'h789, 12'hABC, 1'b0);
        repeat (100) @(negedge clk);
        drive(2'd3, 12'h777, 1'b0);
        drive(2'd1, 12'h5A5, 1'b0);
        chk1("mid_overrun", if2.overrun, 1'b1);
        repeat (32) @(negedge clk);
        chk1("mid_busy", if2.busy, 1'b1);
        chk1("mid_bclk", if2.bclk, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk1("arst_bclk", if2.bclk, 1'b0);
        chk1("arst_fsx", if2.fsx, 1'b0);
        chk1("arst_dx", if2.dx, 1'b0);
        chk1("arst_busy", if2.busy, 1'b0);
        chk1("arst_overrun", if2.overrun, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive(2'd0, 12'h0F0, 1'b0);
        drive(2'd3, 12'h00F, 1'b0);
        wait_idle("post_rst");
        chk64("post_rst_rx", rx2, 64'h00F0_5000_9000_C00F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
